// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write lanes, packed read ports, clear control.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2
);
  logic                      we0;
  logic [ADDR_W-1:0]         waddr0;
  logic [DATA_W-1:0]         wdata0;
  logic                      we1;
  logic [ADDR_W-1:0]         waddr1;
  logic [DATA_W-1:0]         wdata1;
  logic [NREAD*ADDR_W-1:0]   raddr;
  logic [NREAD*DATA_W-1:0]   rdata;
  logic                      clear_req;
  logic                      busy;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clear_req,
    input  rdata, busy
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clear_req,
    output rdata, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD registered reads, two write lanes (lane 1 wins),
// zero register, run-time clear sequencer. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_mp #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       DEPTH   = 32,
  parameter int unsigned       ADDR_W  = 5,
  parameter int unsigned       NREAD   = 2,
  parameter int unsigned       GP_IDX  = 28,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h10008000,
  parameter int unsigned       SP_IDX  = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h7fffeffc
) (
  input logic          clk,
  input logic          reset,
  regfile_mp_if.slave  bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       clr_cnt;
  logic                    busy_q;
  logic [NREAD*DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       rd_next [NREAD];
  logic                    wr0;
  logic                    wr1;

  function automatic logic [DATA_W-1:0] init_val(input int unsigned idx);
    if (idx == GP_IDX) return GP_INIT;
    if (idx == SP_IDX) return SP_INIT;
    return '0;
  endfunction

  // Write lanes are only live in IDLE; address 0 is never written.
  assign wr0 = (state == IDLE) && bus.we0 && (bus.waddr0 != '0);
  assign wr1 = (state == IDLE) && bus.we1 && (bus.waddr1 != '0);

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_next[k] = (ra == '0) ? '0 : mem[ra];
`ifdef REGFILE_BYPASS_EN
      // Lane 1 checked first so it wins forwarding, matching its write priority.
      if (ra != '0) begin
        if (wr1 && (bus.waddr1 == ra))      rd_next[k] = bus.wdata1;
        else if (wr0 && (bus.waddr0 == ra)) rd_next[k] = bus.wdata0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= init_val(i);
      rdata_q <= '0;
      state   <= IDLE;
      clr_cnt <= '0;
      busy_q  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NREAD; k++) rdata_q[k*DATA_W +: DATA_W] <= rd_next[k];
      case (state)
        IDLE: begin
          if (wr0) mem[bus.waddr0] <= bus.wdata0;
          if (wr1) mem[bus.waddr1] <= bus.wdata1;
          if (bus.clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          mem[clr_cnt] <= init_val(32'(clr_cnt));
          if (clr_cnt == ADDR_W'(DEPTH-1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          clr_cnt <= clr_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver pushes reference-model expectations, monitor compares.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam logic [DW-1:0] GP = 32'h10008000;
  localparam logic [DW-1:0] SP = 32'h7fffeffc;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus ();

  regfile_mp #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NREAD(NR),
    .GP_IDX(28), .GP_INIT(GP), .SP_IDX(29), .SP_INIT(SP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NR*DW-1:0] rdata;
    logic             busy;
    int               id;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_id = 0;
  logic [DW-1:0] mm [DEPTH];
  int          clr_idx = -1;   // next entry the clear sequence will restore; -1 when not clearing

  function automatic logic [DW-1:0] rst_val(input int a);
    if (a == 28) return GP;
    if (a == 29) return SP;
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mm[i] = rst_val(i);
    clr_idx = -1;
  endtask

  task automatic idle_inputs();
    bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.raddr = '0; bus.clear_req = 1'b0;
  endtask

  task automatic check_now(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input bit w0, input int a0, input logic [DW-1:0] d0,
                       input bit w1, input int a1, input logic [DW-1:0] d1,
                       input int r0, input int r1, input bit clr);
    exp_t e;
    int   ra [NR];
    logic [DW-1:0] v;
    @(negedge clk);
    bus.we0 = w0; bus.waddr0 = AW'(a0); bus.wdata0 = d0;
    bus.we1 = w1; bus.waddr1 = AW'(a1); bus.wdata1 = d1;
    bus.raddr = {AW'(r1), AW'(r0)};
    bus.clear_req = clr;
    ra[0] = r0; ra[1] = r1;
    e.rdata = '0;
    for (int k = 0; k < NR; k++) begin
      v = (ra[k] == 0) ? '0 : mm[ra[k]];
`ifdef REGFILE_BYPASS_EN
      if (clr_idx < 0 && ra[k] != 0) begin
        if (w1 && a1 == ra[k])      v = d1;
        else if (w0 && a0 == ra[k]) v = d0;
      end
`endif
      e.rdata[k*DW +: DW] = v;
    end
    if (clr_idx >= 0) begin
      mm[clr_idx] = rst_val(clr_idx);
      clr_idx++;
      if (clr_idx == DEPTH) clr_idx = -1;
    end else begin
      if (w0 && a0 != 0) mm[a0] = d0;
      if (w1 && a1 != 0) mm[a1] = d1;
      if (clr) clr_idx = 0;
    end
    e.busy = (clr_idx >= 0);
    e.id   = cyc_id++;
    sb.push_back(e);
  endtask

  task automatic rd(input int r0, input int r1);
    drive(0, 0, '0, 0, 0, '0, r0, r1, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.rdata !== e.rdata) begin
          errors++;
          $display("FAIL rdata cyc=%0d actual=%h required=%h", e.id, bus.rdata, e.rdata);
        end
        checks++;
        if (bus.busy !== e.busy) begin
          errors++;
          $display("FAIL busy cyc=%0d actual=%b required=%b", e.id, bus.busy, e.busy);
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a0, a1, r0, r1;
    idle_inputs();
    model_reset();
    reset = 1'b0;
    #1;
    check_now("reset_rdata", 64'(bus.rdata), 64'd0);
    check_now("reset_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset contents
    rd(28, 29);
    rd(5, 0);

    // Zero register
    drive(1, 0, 32'hdeadbeef, 0, 0, '0, 0, 0, 0);
    rd(0, 0);

    // Write conflict: lane 1 wins
    drive(1, 7, 32'h1, 1, 7, 32'h2, 0, 0, 0);
    rd(7, 0);

    // Same-cycle read of a write
    drive(1, 9, 32'hcafe0001, 0, 0, '0, 9, 9, 0);
    rd(9, 0);

    // Clear sequence with a dropped write during busy
    drive(1, 3, 32'h5a5a5a5a, 1, 29, 32'h5a5a5a5a, 0, 0, 0);
    drive(0, 0, '0, 0, 0, '0, 3, 29, 1);
    drive(1, 3, 32'h11111111, 1, 3, 32'h22222222, 3, 29, 0);
    for (int i = 0; i < 33; i++) rd(3, 29);
    rd(3, 29);

    // Reset in the middle of a clear
    drive(1, 28, 32'h0badf00d, 0, 0, '0, 0, 0, 0);
    drive(0, 0, '0, 0, 0, '0, 28, 0, 1);
    for (int i = 0; i < 10; i++) rd(28, 5);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    check_now("midclear_rdata", 64'(bus.rdata), 64'd0);
    check_now("midclear_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rd(28, 29);

    // Randomized traffic biased toward address collisions
    for (int n = 0; n < 500; n++) begin
      a0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH-1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, DEPTH-1));
      r0 = ($urandom_range(0, 2) == 0) ? a0 : int'($urandom_range(0, DEPTH-1));
      r1 = ($urandom_range(0, 2) == 0) ? a1 : int'($urandom_range(0, DEPTH-1));
      drive(bit'($urandom_range(0, 1)), a0, $urandom,
            bit'($urandom_range(0, 1)), a1, $urandom,
            r0, r1, ($urandom_range(0, 59) == 0));
    end

    rd(0, 0);
    @(posedge clk);
    #2;
    check_now("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the CPU datapath: NREAD synchronous read ports, two write ports, a hardwired zero register, and parameter-driven reset values for the global and stack pointers. It adds three things to the single-write, two-read register file:
- optional write-to-read bypass;
- deterministic conflict resolution between the two write ports;
- a run-time clear sequencer that restores reset contents without asserting reset.

It sits between decode (read addresses) and writeback (two retire lanes).

## Interface
Parameters:
- DATA_W, 32, word width
- DEPTH, 32, number of entries; power of two, ≥ 32
- ADDR_W, 5, address width; equals log2(DEPTH)
- NREAD, 2, number of read ports (1–4)
- GP_IDX, 28, index of global-pointer entry
- GP_INIT, 32'h10008000, reset/clear value of GP_IDX
- SP_IDX, 29, index of stack-pointer entry
- SP_INIT, 32'h7fffeffc, reset/clear value of SP_IDX

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr  in  NREAD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  packed registered read data; port k occupies bits [k*DATA_W +: DATA_W]
- clear_req  in  1  single-cycle pulse; starts the clear sequence
- busy  out  1  high while the clear sequence runs

## Operation
Reset (reset=0), taking effect immediately:
- every entry = 0, except entry GP_IDX = GP_INIT and entry SP_IDX = SP_INIT;
- rdata = 0, busy = 0, FSM = IDLE, clear counter = 0.

Entry 0:
- Always reads 0.
- Writes to address 0 are discarded on both ports.

Writes (IDLE only):
- A port writes when its we is high and its address ≠ 0.
- If both ports write the same address, port 1 wins.

Reads:
- On each edge, rdata[k] captures the entry at raddr[k], or 0 when raddr[k] = 0.
- Bypass behaviour is defined under Configuration.

FSM states: IDLE, CLEAR.
- IDLE → CLEAR on clear_req=1; counter is loaded with 0 and busy=1 from the next cycle.
- In CLEAR, each cycle writes entry[counter] with its reset value, then increments counter.
- When counter = DEPTH-1 is written, the FSM returns to IDLE and busy=0 from the next cycle.
- In CLEAR, we0/we1 are ignored (writes dropped, not queued) and clear_req is ignored.
- Reads in CLEAR return current array contents; entries not yet cleared keep their old values.
- Reset asserted mid-clear aborts the sequence and applies full reset contents.

## Timing
- Read latency: 1 cycle. Address presented before edge N; data valid after edge N until edge N+1.
- Write latency: 1 cycle. Data written at edge N is visible in the array to reads sampled at edge N+1.
- Clear: DEPTH cycles with busy=1, starting the cycle after clear_req is sampled.
- A write presented in the same cycle clear_req is sampled (IDLE) is still performed.
- No combinational path from any input to rdata or busy.

## Configuration
Macro: REGFILE_BYPASS_EN.

Defined:
- If raddr[k] ≠ 0 matches an enabled, non-zero write address in the same cycle (IDLE), rdata[k] captures the incoming write data at that edge.
- Port 1's data is forwarded when both ports match.
- Clear-sequence writes are never forwarded.

Undefined:
- rdata[k] captures the pre-write array value.
- The write becomes readable one cycle later.

## Test plan
- Reset then read: read ports 0/1 at addresses 28/29 → 32'h10008000 / 32'h7fffeffc. Address 5 → 0.
- Zero register: we0=1, waddr0=0, wdata0=32'hdeadbeef, then read address 0 → 0.
- Write conflict: we0=we1=1, both to address 7, wdata0=32'h1, wdata1=32'h2; read 7 next cycle → 32'h2.
- Same-cycle read of a write: write 32'hcafe0001 to address 9 while reading 9. With REGFILE_BYPASS_EN → rdata=32'hcafe0001 that cycle. Without → old value (0), then 32'hcafe0001 the following cycle.
- Clear: load addresses 3 and 29 with 32'h5a5a5a5a, pulse clear_req.
  - busy high for exactly 32 cycles.
  - A write to 3 during busy is dropped.
  - Afterwards address 3 reads 0 and address 29 reads 32'h7fffeffc.
- Reset mid-clear: assert reset at clear cycle 10 → busy=0 and rdata=0 immediately; full reset contents restored, GP_IDX reads 32'h10008000.
